// File: rtl/pwm_seq_ctrl_if.sv
// rtl/pwm_seq_ctrl_if.sv - configuration handshake bundle for pwm_seq_ctrl
interface pwm_seq_ctrl_if #(
  parameter int W = 16
);
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_period;
  logic [W-1:0] cfg_duty;
  logic         cfg_duty_sel;

  modport master (
    output cfg_valid, cfg_period, cfg_duty, cfg_duty_sel,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_duty, cfg_duty_sel,
    output cfg_ready
  );
endinterface

// File: rtl/pwm_seq_ctrl.sv
// rtl/pwm_seq_ctrl.sv - sequencer for one pwm_core: start/stop, bursts, boundary-aligned config updates
module pwm_seq_ctrl #(
  parameter int W          = 16,
  parameter int ARM_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  pwm_seq_ctrl_if.slave cfg,
  input  logic [W-1:0]  burst_len,
  output logic [W-1:0]  period_reg,
  output logic [W-1:0]  duty_reg,
  output logic          duty_sel,
  output logic          pwm_core_EN,
  output logic          main_counter_EN,
  output logic          o_pwm_EN,
  output logic          period_tick,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  localparam int AW = (ARM_CYCLES < 2) ? 1 : $clog2(ARM_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

  state_t        state, state_n;
  logic [W-1:0]  cnt, burst_cnt, burst_lim;
  logic [W-1:0]  sh_period, sh_duty;
  logic          sh_sel, sh_valid;
  logic [AW-1:0] arm_cnt;
  logic          running, boundary, ready_c, hs, bad_cfg, burst_end, done_n, arm_last;
  logic [W-1:0]  duty_clamped;

  assign running      = (state == RUN) || (state == DRAIN);
  assign boundary     = running && (cnt == period_reg - W'(1));
  assign period_tick  = boundary;
  assign hs           = cfg.cfg_valid && ready_c;
  assign bad_cfg      = cfg.cfg_period < W'(2);
  assign duty_clamped = (cfg.cfg_duty > cfg.cfg_period) ? cfg.cfg_period : cfg.cfg_duty;
  assign burst_end    = (burst_lim != '0) && (burst_cnt + W'(1) == burst_lim);
  assign arm_last     = (arm_cnt == AW'(ARM_CYCLES - 1));
  assign cfg.cfg_ready = ready_c;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    ready_c = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (start && !stop) state_n = ARM;
      end
      ARM: begin
        if (stop) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (arm_last) begin
          state_n = RUN;
        end
      end
      RUN: begin
        ready_c = !sh_valid;
        // burst completion takes priority over a stop on the same boundary
        if (boundary && burst_end) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (stop) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (boundary) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      period_reg      <= W'(100);
      duty_reg        <= '0;
      duty_sel        <= 1'b0;
      pwm_core_EN     <= 1'b0;
      main_counter_EN <= 1'b0;
      o_pwm_EN        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      cfg_err         <= 1'b0;
      cnt             <= '0;
      arm_cnt         <= '0;
      burst_cnt       <= '0;
      burst_lim       <= '0;
      sh_period       <= '0;
      sh_duty         <= '0;
      sh_sel          <= 1'b0;
      sh_valid        <= 1'b0;
    end else begin
      pwm_core_EN     <= (state_n != IDLE);
      main_counter_EN <= (state_n == RUN) || (state_n == DRAIN);
      o_pwm_EN        <= (state_n == RUN) || (state_n == DRAIN);
      busy            <= (state_n != IDLE);
      done            <= done_n;
      cfg_err         <= hs && bad_cfg;

      arm_cnt <= (state == ARM) ? arm_cnt + AW'(1) : '0;
      cnt     <= (running && !boundary) ? cnt + W'(1) : '0;

      if (state == IDLE && start && !stop) begin
        burst_lim <= burst_len;
        burst_cnt <= '0;
      end else if (boundary) begin
        burst_cnt <= burst_cnt + W'(1);
      end

      if (state == RUN && boundary && sh_valid) begin
        period_reg <= sh_period;
        duty_reg   <= sh_duty;
        duty_sel   <= sh_sel;
        sh_valid   <= 1'b0;
      end

      // shadow is only writable while empty, so this never collides with the copy above
      if (hs && !bad_cfg) begin
        if (state == IDLE) begin
          period_reg <= cfg.cfg_period;
          duty_reg   <= duty_clamped;
          duty_sel   <= cfg.cfg_duty_sel;
        end else begin
          sh_period <= cfg.cfg_period;
          sh_duty   <= duty_clamped;
          sh_sel    <= cfg.cfg_duty_sel;
          sh_valid  <= 1'b1;
        end
      end

      if (state_n == IDLE) sh_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// tb/tb_pwm_seq_ctrl.sv - directed/random bench for pwm_seq_ctrl
module tb_pwm_seq_ctrl;
  localparam int W    = 16;
  localparam int ARMC = 1;

  logic         clk, rst, start, stop;
  logic [W-1:0] burst_len, period_reg, duty_reg;
  logic         duty_sel, pwm_core_EN, main_counter_EN, o_pwm_EN;
  logic         period_tick, busy, done, cfg_err;

  pwm_seq_ctrl_if #(.W(W)) cfg_bus ();

  pwm_seq_ctrl #(.W(W), .ARM_CYCLES(ARMC)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg(cfg_bus),
    .burst_len(burst_len), .period_reg(period_reg), .duty_reg(duty_reg),
    .duty_sel(duty_sel), .pwm_core_EN(pwm_core_EN), .main_counter_EN(main_counter_EN),
    .o_pwm_EN(o_pwm_EN), .period_tick(period_tick), .busy(busy), .done(done),
    .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rc    = 0;
  int ticks[$];
  int done_cnt, done_rc;
  int m_period, m_duty, m_sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rc++;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      if (period_tick === 1'b1) ticks.push_back(rc);
      if (done === 1'b1) begin
        done_cnt++;
        done_rc = rc;
      end
      tick();
    end
  endtask

  function automatic int clamp(input int p, input int d);
    return (d > p) ? p : d;
  endfunction

  task automatic send_cfg(input int p, input int d, input int s);
    check("idle_ready", cfg_bus.cfg_ready, 1);
    cfg_bus.cfg_valid    = 1'b1;
    cfg_bus.cfg_period   = W'(p);
    cfg_bus.cfg_duty     = W'(d);
    cfg_bus.cfg_duty_sel = s[0];
    tick();
    cfg_bus.cfg_valid = 1'b0;
    if (p >= 2) begin
      m_period = p;
      m_duty   = clamp(p, d);
      m_sel    = s;
    end
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("arm_core_en", pwm_core_EN, 1);
    check("arm_cnt_en", main_counter_EN, 0);
    check("arm_out_en", o_pwm_EN, 0);
    repeat (ARMC) tick();
    rc = 0;
    ticks.delete();
    done_cnt = 0;
    check("run_cnt_en", main_counter_EN, 1);
    check("run_out_en", o_pwm_EN, 1);
  endtask

  initial begin
    int p, d, s, n;
    rst = 1'b0; start = 1'b0; stop = 1'b0; burst_len = '0;
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_period = '0;
    cfg_bus.cfg_duty = '0; cfg_bus.cfg_duty_sel = 1'b0;
    m_period = 100; m_duty = 0; m_sel = 0;

    tick(); tick();
    check("rst_period", period_reg, 100);
    check("rst_duty", duty_reg, 0);
    check("rst_sel", duty_sel, 0);
    check("rst_core_en", pwm_core_EN, 0);
    check("rst_cnt_en", main_counter_EN, 0);
    check("rst_out_en", o_pwm_EN, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cfg_bus.cfg_ready, 1);
    check("rst_done", done, 0);
    rst = 1'b1;
    tick();

    // random configurations applied directly in IDLE
    for (int i = 0; i < 5; i++) begin
      p = int'($urandom_range(2, 300));
      d = int'($urandom_range(0, 400));
      s = int'($urandom_range(0, 1));
      send_cfg(p, d, s);
      check("idle_period", period_reg, m_period);
      check("idle_duty", duty_reg, m_duty);
      check("idle_sel", duty_sel, m_sel);
    end

    send_cfg(int'($urandom_range(0, 1)), 5, 1);
    check("rej_err", cfg_err, 1);
    check("rej_period", period_reg, m_period);
    check("rej_duty", duty_reg, m_duty);
    tick();
    check("rej_err_pulse", cfg_err, 0);

    send_cfg(20, 30, 0);
    check("clamp_duty", duty_reg, 20);

    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", busy, 0);
    check("ss_core_en", pwm_core_EN, 0);

    start = 1'b1;
    tick();
    start = 1'b0; stop = 1'b1;
    check("armstop_in_arm", busy, 1);
    tick();
    stop = 1'b0;
    check("armstop_busy", busy, 0);
    check("armstop_done", done, 1);
    check("armstop_core_en", pwm_core_EN, 0);
    tick();
    check("armstop_done_pulse", done, 0);

    // continuous run with an update offered mid-period
    burst_len = '0;
    send_cfg(100, 25, 0);
    check("a_period", period_reg, 100);
    check("a_duty", duty_reg, 25);
    start_run();
    run_cycles(140);
    check("a_tick_n", ticks.size(), 1);
    if (ticks.size() > 0) check("a_tick0", ticks[0], 99);
    check("a_ready_before", cfg_bus.cfg_ready, 1);
    cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_period = W'(200);
    cfg_bus.cfg_duty = W'(100); cfg_bus.cfg_duty_sel = 1'b0;
    tick();
    cfg_bus.cfg_valid = 1'b0;
    check("a_ready_shadow", cfg_bus.cfg_ready, 0);
    check("a_period_hold", period_reg, 100);
    check("a_duty_hold", duty_reg, 25);
    run_cycles(59);
    check("a_tick_n2", ticks.size(), 2);
    if (ticks.size() > 1) check("a_tick1", ticks[1], 199);
    check("a_period_new", period_reg, 200);
    check("a_duty_new", duty_reg, 100);
    check("a_ready_after", cfg_bus.cfg_ready, 1);
    ticks.delete();
    run_cycles(210);
    check("a_tick_n3", ticks.size(), 1);
    if (ticks.size() > 0) check("a_tick2", ticks[0], 200 + 200 - 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    done_cnt = 0;
    run_cycles(190);
    check("a_drain_done_n", done_cnt, 1);
    check("a_drain_done_at", done_rc, 600);
    check("a_drain_busy", busy, 0);

    // bursts: the fixed case then a random one
    for (int b = 0; b < 2; b++) begin
      p = (b == 0) ? 20 : int'($urandom_range(2, 25));
      n = (b == 0) ? 3 : int'($urandom_range(1, 4));
      send_cfg(p, int'($urandom_range(0, 30)), 0);
      burst_len = W'(n);
      start_run();
      run_cycles(n * p + 5);
      check("burst_ticks", ticks.size(), n);
      for (int k = 0; k < n && k < ticks.size(); k++)
        check("burst_tick_at", ticks[k], (k + 1) * p - 1);
      check("burst_done_n", done_cnt, 1);
      check("burst_done_at", done_rc, n * p);
      check("burst_busy", busy, 0);
      check("burst_core_en", pwm_core_EN, 0);
      check("burst_out_en", o_pwm_EN, 0);
    end
    burst_len = '0;

    // stop at cnt=5 discards the pending shadow
    p = int'($urandom_range(10, 40));
    d = int'($urandom_range(0, 50));
    send_cfg(p, d, 0);
    start_run();
    run_cycles(2);
    cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_period = W'(p + 7);
    cfg_bus.cfg_duty = W'(3); cfg_bus.cfg_duty_sel = 1'b1;
    tick();
    cfg_bus.cfg_valid = 1'b0;
    run_cycles(2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("drain_cnt_en", main_counter_EN, 1);
    check("drain_ready", cfg_bus.cfg_ready, 0);
    ticks.delete();
    done_cnt = 0;
    run_cycles(p);
    check("drain_ticks", ticks.size(), 1);
    if (ticks.size() > 0) check("drain_tick_at", ticks[0], p - 1);
    check("drain_done_at", done_rc, p);
    check("drain_period", period_reg, p);
    check("drain_duty", duty_reg, clamp(p, d));
    check("drain_sel", duty_sel, 0);
    check("drain_core_en", pwm_core_EN, 0);

    // reset in the middle of a run
    send_cfg(50, 20, 1);
    start_run();
    run_cycles(10);
    cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_period = W'(60);
    cfg_bus.cfg_duty = W'(9); cfg_bus.cfg_duty_sel = 1'b1;
    tick();
    cfg_bus.cfg_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("mrst_period", period_reg, 100);
    check("mrst_duty", duty_reg, 0);
    check("mrst_sel", duty_sel, 0);
    check("mrst_busy", busy, 0);
    check("mrst_core_en", pwm_core_EN, 0);
    check("mrst_ready", cfg_bus.cfg_ready, 1);
    rst = 1'b1;
    tick();
    start_run();
    run_cycles(101);
    check("mrst_ticks", ticks.size(), 1);
    if (ticks.size() > 0) check("mrst_tick_at", ticks[0], 99);
    check("mrst_shadow_lost", period_reg, 100);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    run_cycles(100);
    check("mrst_stop_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
